// File: rtl/sic1_host_seq.sv
// sic1_host_seq: host-side command sequencer for the SIC-1 SUBLEQ core.
// Turns SET_PC / WRITE / RUN / STEP commands into core_set_pc, core_set_data
// and core_run pin activity, and reports how each run ended.
// Optional feature: define SIC1_SEQ_ICOUNT_EN for a 16-bit saturating
// retired-instruction counter on icount (tied to 0 otherwise).
module sic1_host_seq #(
   parameter int unsigned BUDGET_W = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [1:0]          cmd_op,
   input  logic [BUDGET_W-1:0] cmd_data,
   input  logic                abort,
   input  logic                core_halted,
   output logic [7:0]          core_ui_in,
   output logic                core_set_pc,
   output logic                core_set_data,
   output logic                core_run,
   output logic                busy,
   output logic                done,
   output logic [1:0]          status,
   output logic [15:0]         icount
);

   typedef enum logic [2:0] {
      S_IDLE, S_APPLY, S_RUNNING, S_STOPPING, S_DONE
   } state_t;

   typedef enum logic [1:0] {
      OP_SET_PC = 2'd0, OP_WRITE = 2'd1, OP_RUN = 2'd2, OP_STEP = 2'd3
   } op_t;

   typedef enum logic [1:0] {
      ST_BUDGET = 2'd0, ST_SELF_HALT = 2'd1, ST_START_FAIL = 2'd2, ST_ABORTED = 2'd3
   } stat_t;

   state_t              state_q, state_d;
   logic [7:0]          ui_q, ui_d;
   logic                set_pc_q, set_pc_d;
   logic                set_data_q, set_data_d;
   logic                run_q, run_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   stat_t               status_q, status_d;
   stat_t               pend_q, pend_d;
   logic                phase_q, phase_d;
   logic [1:0]          age_q, age_d;
   logic                lim_q, lim_d;
   logic [BUDGET_W-1:0] rem_q, rem_d;
   logic [15:0]         icnt_q, icnt_d;
   logic                accept;
   logic                core_active;
   logic                retire;

   assign cmd_ready     = (state_q == S_IDLE);
   assign core_ui_in    = ui_q;
   assign core_set_pc   = set_pc_q;
   assign core_set_data = set_data_q;
   assign core_run      = run_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign status        = status_q;

`ifdef SIC1_SEQ_ICOUNT_EN
   assign icount = icnt_q;
`else
   assign icount = '0;
`endif

   // Next-state and next-output computation for the whole sequencer
   always_comb begin
      state_d    = state_q;
      ui_d       = ui_q;
      set_pc_d   = 1'b0;
      set_data_d = 1'b0;
      run_d      = run_q;
      status_d   = status_q;
      pend_d     = pend_q;
      phase_d    = phase_q;
      age_d      = age_q;
      lim_d      = lim_q;
      rem_d      = rem_q;
      icnt_d     = icnt_q;

      accept      = cmd_valid && (state_q == S_IDLE);
      // The core keeps cycling while it is not halted, also after run drops
      // (it finishes the instruction in flight), so phase and retire counting
      // continue through STOPPING.
      core_active = ((state_q == S_RUNNING) || (state_q == S_STOPPING)) && !core_halted;
      retire      = core_active && phase_q;

      if (core_active) begin
         phase_d = ~phase_q;
      end
      if (retire) begin
         rem_d = rem_q - 1'b1;
`ifdef SIC1_SEQ_ICOUNT_EN
         if (icnt_q != 16'hFFFF) begin
            icnt_d = icnt_q + 16'd1;
         end
`endif
      end

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               case (op_t'(cmd_op))
                  OP_SET_PC: begin
                     ui_d     = cmd_data[7:0];
                     set_pc_d = 1'b1;
                     state_d  = S_APPLY;
                  end
                  OP_WRITE: begin
                     ui_d       = cmd_data[7:0];
                     set_data_d = 1'b1;
                     state_d    = S_APPLY;
                  end
                  default: begin
                     if (op_t'(cmd_op) == OP_STEP) begin
                        rem_d = BUDGET_W'(1);
                        lim_d = 1'b1;
                     end else begin
                        rem_d = cmd_data;
                        lim_d = (cmd_data != '0);
                     end
                     phase_d = 1'b0;
                     age_d   = 2'd0;
                     icnt_d  = '0;
                     run_d   = 1'b1;
                     state_d = S_RUNNING;
                  end
               endcase
            end
         end
         S_APPLY: begin
            state_d = S_IDLE;
         end
         S_RUNNING: begin
            // age: 0 = first run cycle, 1 = start-check cycle, 2 = afterwards
            if (age_q != 2'd2) begin
               age_d = age_q + 2'd1;
            end
            if ((age_q == 2'd1) && core_halted) begin
               status_d = ST_START_FAIL;
               run_d    = 1'b0;
               state_d  = S_DONE;
            end else if ((age_q == 2'd2) && core_halted) begin
               status_d = ST_SELF_HALT;
               run_d    = 1'b0;
               state_d  = S_DONE;
            end else if (lim_q && !core_halted && !phase_q && (rem_q == BUDGET_W'(1))) begin
               // READ_INST of the last budgeted instruction: drop run so the
               // core halts right after its READ_DATA cycle.
               pend_d  = ST_BUDGET;
               run_d   = 1'b0;
               state_d = S_STOPPING;
            end else if (abort) begin
               pend_d  = ST_ABORTED;
               run_d   = 1'b0;
               state_d = S_STOPPING;
            end
         end
         S_STOPPING: begin
            if (core_halted) begin
               status_d = pend_q;
               state_d  = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            run_d   = 1'b0;
         end
      endcase

      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_DONE);
   end

   // State and registered outputs, synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         ui_q       <= '0;
         set_pc_q   <= 1'b0;
         set_data_q <= 1'b0;
         run_q      <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         status_q   <= ST_BUDGET;
         pend_q     <= ST_BUDGET;
         phase_q    <= 1'b0;
         age_q      <= 2'd0;
         lim_q      <= 1'b0;
         rem_q      <= '0;
         icnt_q     <= '0;
      end else begin
         state_q    <= state_d;
         ui_q       <= ui_d;
         set_pc_q   <= set_pc_d;
         set_data_q <= set_data_d;
         run_q      <= run_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         status_q   <= status_d;
         pend_q     <= pend_d;
         phase_q    <= phase_d;
         age_q      <= age_d;
         lim_q      <= lim_d;
         rem_q      <= rem_d;
         icnt_q     <= icnt_d;
      end
   end

endmodule

// File: tb/tb_sic1_host_seq.sv
// Testbench for sic1_host_seq with a behavioural SIC-1 core model
// (SUBLEQ: mem[A] -= mem[B]; branch to C if result <= 0; halt when PC > 252).
module tb_sic1_host_seq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cmd_valid = 1'b0;
   logic [1:0]  cmd_op = 2'd0;
   logic [7:0]  cmd_data = 8'd0;
   logic        abort = 1'b0;
   logic        cmd_ready, core_halted, core_set_pc, core_set_data, core_run, busy, done;
   logic [7:0]  core_ui_in;
   logic [1:0]  status;
   logic [15:0] icount;

   int n_cmp = 0;
   int n_bad = 0;

`ifdef SIC1_SEQ_ICOUNT_EN
   localparam bit ICNT_EN = 1'b1;
`else
   localparam bit ICNT_EN = 1'b0;
`endif

   sic1_host_seq #(.BUDGET_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_data(cmd_data), .abort(abort), .core_halted(core_halted),
      .core_ui_in(core_ui_in), .core_set_pc(core_set_pc), .core_set_data(core_set_data),
      .core_run(core_run), .busy(busy), .done(done), .status(status), .icount(icount)
   );

   always #5 clk = ~clk;

   // Core model: halted until run is seen with a legal PC, then alternates
   // READ_INST / READ_DATA; executes at the end of READ_DATA.
   logic [7:0] mem [256];
   logic [7:0] m_pc = 8'd0;
   logic       m_halted = 1'b1;
   logic       m_rd = 1'b0;
   int         rd_cnt = 0;
   assign core_halted = m_halted;

   always @(posedge clk) begin
      logic [7:0] a, b, c, r, npc;
      if (m_halted) begin
         if (core_set_pc) m_pc <= core_ui_in;
         else if (core_set_data) begin
            mem[m_pc] <= core_ui_in;
            m_pc <= m_pc + 8'd1;
         end else if (core_run && (m_pc <= 8'd252)) begin
            m_halted <= 1'b0;
            m_rd <= 1'b0;
         end
      end else if (!m_rd) begin
         m_rd <= 1'b1;
      end else begin
         a = mem[m_pc];
         b = mem[m_pc + 8'd1];
         c = mem[m_pc + 8'd2];
         r = mem[a] - mem[b];
         npc = ($signed(r) <= 0) ? c : (m_pc + 8'd3);
         mem[a] <= r;
         m_pc <= npc;
         m_rd <= 1'b0;
         rd_cnt <= rd_cnt + 1;
         if (!core_run || (npc > 8'd252)) m_halted <= 1'b1;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready();
      int w = 0;
      while (!cmd_ready && w < 50) begin
         step();
         w++;
      end
      n_cmp++;
      if (cmd_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL ready_timeout: cmd_ready=%b required 1", cmd_ready);
      end
   endtask

   task automatic cfg(input logic [1:0] op, input logic [7:0] d);
      wait_ready();
      cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
      step();
      cmd_valid = 1'b0;
      step();
   endtask

   // Issues RUN/STEP at cycle 0 and records, in cycles after acceptance,
   // when core_run first reads low, when core_halted rises and when done pulses.
   task automatic run_seq(input logic [1:0] op, input logic [7:0] d, input int ab_cyc,
                          output int run_low, output int done_c, output int rise, output int ret);
      int   rd0;
      logic prev_h;
      run_low = -1; done_c = -1; rise = -1;
      wait_ready();
      cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
      rd0 = rd_cnt;
      step();
      cmd_valid = 1'b0;
      prev_h = core_halted;
      for (int k = 1; k <= 60 && done_c < 0; k++) begin
         if (!core_run && run_low < 0) run_low = k;
         if (k >= 2 && core_halted && !prev_h && rise < 0) rise = k;
         prev_h = core_halted;
         if (done) done_c = k;
         abort = (k == ab_cyc);
         if (done_c < 0) step();
      end
      abort = 1'b0;
      ret = rd_cnt - rd0;
      n_cmp++;
      if (done_c < 0) begin
         n_bad++;
         $display("FAIL done_timeout: no done within 60 cycles");
      end
   endtask

   task automatic load_loop();
      cfg(2'd0, 8'h00);
      cfg(2'd1, 8'h00);
      cfg(2'd1, 8'h00);
      cfg(2'd1, 8'h00);
      cfg(2'd0, 8'h00);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) step();
      n_cmp += 6;
      if (core_run !== 1'b0)      begin n_bad++; $display("FAIL rst_run: got %b want 0", core_run); end
      if (core_set_pc !== 1'b0)   begin n_bad++; $display("FAIL rst_setpc: got %b want 0", core_set_pc); end
      if (core_set_data !== 1'b0) begin n_bad++; $display("FAIL rst_setdata: got %b want 0", core_set_data); end
      if (busy !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL rst_busy_done: got %b%b want 00", busy, done); end
      if (status !== 2'd0)        begin n_bad++; $display("FAIL rst_status: got %0d want 0", status); end
      if (icount !== 16'd0 || core_ui_in !== 8'd0) begin n_bad++; $display("FAIL rst_icnt_ui: got %h/%h want 0/0", icount, core_ui_in); end
      rst_n = 1'b1;
      step();
      n_cmp++;
      if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready: got %b want 1", cmd_ready); end
   endtask

   task automatic test_back_to_back();
      wait_ready();
      cmd_valid = 1'b1; cmd_op = 2'd0; cmd_data = 8'h10;
      step();                                   // cycle 1
      n_cmp += 3;
      if (core_set_pc !== 1'b1 || core_set_data !== 1'b0) begin n_bad++; $display("FAIL b2b_setpc: got pc=%b data=%b want 1/0", core_set_pc, core_set_data); end
      if (core_ui_in !== 8'h10) begin n_bad++; $display("FAIL b2b_ui0: got %h want 10", core_ui_in); end
      if (cmd_ready !== 1'b0)   begin n_bad++; $display("FAIL b2b_ready1: got %b want 0", cmd_ready); end
      cmd_op = 2'd1; cmd_data = 8'hAA;
      step();                                   // cycle 2
      n_cmp++;
      if (cmd_ready !== 1'b1 || core_set_pc !== 1'b0) begin n_bad++; $display("FAIL b2b_c2: got ready=%b pc=%b want 1/0", cmd_ready, core_set_pc); end
      step();                                   // cycle 3
      n_cmp += 2;
      if (core_set_data !== 1'b1 || core_ui_in !== 8'hAA) begin n_bad++; $display("FAIL b2b_wr1: got %b/%h want 1/aa", core_set_data, core_ui_in); end
      if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_ready3: got %b want 0", cmd_ready); end
      cmd_data = 8'hBB;
      step();                                   // cycle 4
      step();                                   // cycle 5
      cmd_valid = 1'b0;
      n_cmp++;
      if (core_set_data !== 1'b1 || core_ui_in !== 8'hBB) begin n_bad++; $display("FAIL b2b_wr2: got %b/%h want 1/bb", core_set_data, core_ui_in); end
      step();
      n_cmp += 2;
      if (core_set_data !== 1'b0) begin n_bad++; $display("FAIL b2b_end: got %b want 0", core_set_data); end
      if (mem[8'h10] !== 8'hAA || mem[8'h11] !== 8'hBB || m_pc !== 8'h12) begin
         n_bad++; $display("FAIL b2b_mem: got %h %h pc=%h want aa bb pc=12", mem[8'h10], mem[8'h11], m_pc);
      end
   endtask

   task automatic test_budget();
      int rl, dc, rs, rt;
      load_loop();
      run_seq(2'd2, 8'd3, -1, rl, dc, rs, rt);
      n_cmp += 5;
      if (rl !== 7)  begin n_bad++; $display("FAIL bud_runlow: got %0d want 7", rl); end
      if (dc !== 9)  begin n_bad++; $display("FAIL bud_done: got %0d want 9", dc); end
      if (status !== 2'd0) begin n_bad++; $display("FAIL bud_status: got %0d want 0", status); end
      if (rt !== 3)  begin n_bad++; $display("FAIL bud_retired: got %0d want 3", rt); end
      if (icount !== (ICNT_EN ? 16'd3 : 16'd0)) begin n_bad++; $display("FAIL bud_icount: got %0d want %0d", icount, ICNT_EN ? 3 : 0); end
      step();
      n_cmp++;
      if (done !== 1'b0 || cmd_ready !== 1'b1) begin n_bad++; $display("FAIL bud_after: got done=%b ready=%b want 0/1", done, cmd_ready); end
   endtask

   task automatic test_start_fail();
      int rl, dc, rs, rt;
      cfg(2'd0, 8'hFD);
      run_seq(2'd2, 8'd0, -1, rl, dc, rs, rt);
      n_cmp += 5;
      if (dc !== 3) begin n_bad++; $display("FAIL sf_done: got %0d want 3", dc); end
      if (rl !== 3) begin n_bad++; $display("FAIL sf_runlow: got %0d want 3", rl); end
      if (status !== 2'd2) begin n_bad++; $display("FAIL sf_status: got %0d want 2", status); end
      if (rt !== 0) begin n_bad++; $display("FAIL sf_retired: got %0d want 0", rt); end
      if (icount !== 16'd0) begin n_bad++; $display("FAIL sf_icount: got %0d want 0", icount); end
   endtask

   task automatic test_self_halt();
      int rl, dc, rs, rt;
      cfg(2'd0, 8'h20);
      cfg(2'd1, 8'h30);
      cfg(2'd1, 8'h30);
      cfg(2'd1, 8'hFF);
      cfg(2'd0, 8'h30);
      cfg(2'd1, 8'h07);
      cfg(2'd0, 8'h20);
      run_seq(2'd2, 8'd0, -1, rl, dc, rs, rt);
      n_cmp += 5;
      if (status !== 2'd1) begin n_bad++; $display("FAIL sh_status: got %0d want 1", status); end
      if (dc !== 5 || rs !== 4) begin n_bad++; $display("FAIL sh_timing: got done=%0d rise=%0d want 5/4", dc, rs); end
      if (rl !== 5) begin n_bad++; $display("FAIL sh_runlow: got %0d want 5", rl); end
      if (rt !== 1) begin n_bad++; $display("FAIL sh_retired: got %0d want 1", rt); end
      if (icount !== (ICNT_EN ? 16'd1 : 16'd0)) begin n_bad++; $display("FAIL sh_icount: got %0d want %0d", icount, ICNT_EN ? 1 : 0); end
   endtask

   task automatic test_abort();
      int rl, dc, rs, rt;
      load_loop();
      run_seq(2'd2, 8'd0, 10, rl, dc, rs, rt);
      n_cmp += 5;
      if (rl !== 11) begin n_bad++; $display("FAIL ab_runlow: got %0d want 11", rl); end
      if (status !== 2'd3) begin n_bad++; $display("FAIL ab_status: got %0d want 3", status); end
      if (rs !== 12 || dc !== 13 || (dc - rs) > 3) begin n_bad++; $display("FAIL ab_timing: got rise=%0d done=%0d want 12/13", rs, dc); end
      if (rt !== 5) begin n_bad++; $display("FAIL ab_retired: got %0d want 5", rt); end
      if (icount !== (ICNT_EN ? 16'd5 : 16'd0)) begin n_bad++; $display("FAIL ab_icount: got %0d want %0d", icount, ICNT_EN ? 5 : 0); end
   endtask

   task automatic test_reset_mid_run();
      int rl, dc, rs, rt;
      load_loop();
      wait_ready();
      cmd_valid = 1'b1; cmd_op = 2'd2; cmd_data = 8'd0;
      step();
      cmd_valid = 1'b0;
      repeat (4) step();                        // cycle 5
      n_cmp++;
      if (core_run !== 1'b1 || busy !== 1'b1) begin n_bad++; $display("FAIL mr_running: got run=%b busy=%b want 1/1", core_run, busy); end
      rst_n = 1'b0;
      step();
      n_cmp += 2;
      if (core_run !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL mr_outs: got run=%b busy=%b done=%b want 000", core_run, busy, done); end
      if (status !== 2'd0 || icount !== 16'd0) begin n_bad++; $display("FAIL mr_status: got %0d/%0d want 0/0", status, icount); end
      rst_n = 1'b1;
      step();
      n_cmp++;
      if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL mr_ready: got %b want 1", cmd_ready); end
      repeat (4) step();
      cfg(2'd0, 8'h00);
      run_seq(2'd3, 8'h55, -1, rl, dc, rs, rt);
      n_cmp += 4;
      if (rt !== 1) begin n_bad++; $display("FAIL step_retired: got %0d want 1", rt); end
      if (rl !== 3 || dc !== 5) begin n_bad++; $display("FAIL step_timing: got runlow=%0d done=%0d want 3/5", rl, dc); end
      if (status !== 2'd0) begin n_bad++; $display("FAIL step_status: got %0d want 0", status); end
      if (icount !== (ICNT_EN ? 16'd1 : 16'd0)) begin n_bad++; $display("FAIL step_icount: got %0d want %0d", icount, ICNT_EN ? 1 : 0); end
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_budget();
      test_start_fail();
      test_self_halt();
      test_abort();
      test_reset_mid_run();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/sic1_host_seq.md
# sic1_host_seq

Host-side command sequencer for the SIC-1 SUBLEQ core. It accepts a valid/ready command stream: set PC, write a program byte, run for N instructions, or single-step. It converts each command into the exact `set_pc` / `set_data` / `run` pulse sequence the core's control pins expect. It watches the core's `halted` flag to report how and when each run ended, so a host MCU or test harness can load and step programs without hand-timing the core pins.

## Interface
Parameters:
- `BUDGET_W`, 8: width of the run instruction budget; equals `cmd_data` width.

Ports:
- `clk`  in  1: clock.
- `rst_n`  in  1: synchronous active-low reset.
- `cmd_valid`  in  1: command present.
- `cmd_ready`  out  1: sequencer can accept a command.
- `cmd_op`  in  2: 0 SET_PC, 1 WRITE, 2 RUN, 3 STEP.
- `cmd_data`  in  8: address, data byte or run budget (0 = unlimited).
- `abort`  in  1: level; requests end of the current run.
- `core_halted`  in  1: core halted flag.
- `core_ui_in`  out  8: byte driven to the core's data input.
- `core_set_pc`  out  1: core set-PC strobe.
- `core_set_data`  out  1: core write-and-increment strobe.
- `core_run`  out  1: core run level.
- `busy`  out  1: high in any state except IDLE.
- `done`  out  1: one-cycle pulse at the end of a RUN/STEP.
- `status`  out  2: end reason, valid from `done` until the next RUN/STEP is accepted. 0 BUDGET, 1 SELF_HALT, 2 START_FAIL, 3 ABORTED.
- `icount`  out  16: retired-instruction count (see Configuration).

## Operation
- States: IDLE, APPLY, RUNNING, STOPPING, DONE.
- `cmd_ready` = (state == IDLE). A command is accepted on `cmd_valid && cmd_ready`.
- In IDLE, `core_run`, `core_set_pc` and `core_set_data` are all 0.
- SET_PC: go to APPLY. In APPLY, `core_ui_in = data` and `core_set_pc = 1` for exactly one cycle, then return to IDLE.
- WRITE: as SET_PC, but pulses `core_set_data`. The core writes the byte at its PC and increments PC.
- RUN: latch `budget = cmd_data`, clear the phase bit and `icount`, go to RUNNING with `core_run = 1`. STEP is RUN with budget 1; `cmd_data` is ignored.
- RUNNING:
  - Phase bit toggles on every cycle where `core_halted = 0`. A cycle with phase = 1 is a core READ_DATA cycle; that instruction retires at the end of it.
  - Start check: in the second cycle of RUNNING, if `core_halted = 1`, the core refused to start (PC > 252). Set `status = 2`, drop `core_run`, go to DONE.
  - Budget: with `budget != 0`, `core_run` is cleared at the clock edge that ends the READ_INST cycle of instruction number `budget`. Go to STOPPING with pending `status = 0`.
  - Abort: `abort = 1` in RUNNING clears `core_run` at the next edge. Go to STOPPING with pending `status = 3`. Budget exhaustion takes priority if both occur on the same edge.
  - Self-halt: `core_halted` returns to 1 while `core_run = 1` after the start check. Set `status = 1`, clear `core_run`, go to DONE.
- STOPPING: wait for `core_halted = 1`, then go to DONE.
- DONE: `done = 1` for one cycle, then IDLE.
- `abort` is ignored outside RUNNING.
- Reset: state IDLE, every output 0, `status = 0`, `icount = 0`. A reset mid-run drops `core_run` immediately (registered, so 0 from the first cycle after the reset edge).

## Timing
- Command accepted at cycle 0:
  - SET_PC/WRITE strobe is at cycle 1; `cmd_ready` returns at cycle 2. Throughput is one config command per 2 cycles.
  - RUN: `core_run` is high from cycle 1 (rising edge guaranteed, since it was low in IDLE). Core READ_INST is at cycle 2; instruction k's READ_DATA is at cycle 1+2k.
  - Budget N: `core_run` is low at cycle 1+2N; `core_halted` is 1 at cycle 2+2N; `done` is at cycle 3+2N.
  - START_FAIL: `done` at cycle 3.
- All outputs are registered; no combinational path from `cmd_*` to core pins.

## Configuration
- `SIC1_SEQ_ICOUNT_EN` defined:
  - `icount` is a 16-bit saturating counter (stops at 0xFFFF).
  - Increments on each retired instruction; cleared on RUN/STEP acceptance; holds its value after DONE.
- Not defined:
  - `icount` is tied to 0.
  - Budget tracking uses an internal 8-bit down-counter only.

## Test plan
- SET_PC 0x10, WRITE 0xAA, WRITE 0xBB, issued back-to-back -> `core_set_pc` pulse with `core_ui_in = 0x10`, then two `core_set_data` pulses carrying 0xAA and 0xBB. `cmd_ready` low on each strobe cycle.
- Core at PC 0, infinite-loop program, RUN budget 3 -> exactly 3 READ_DATA cycles, `core_run` low at cycle 7, `done` at cycle 9, `status = 0`, `icount = 3`.
- SET_PC 0xFD, then RUN 0 -> core never leaves halt; `done` at cycle 3, `status = 2`, `icount = 0`.
- Program whose first instruction branches to 0xFF, RUN 0 -> core self-halts after one instruction; `status = 1`, `icount = 1`.
- RUN 0 on a looping program, `abort` asserted at cycle 10 -> `core_run` low at cycle 11, `status = 3`, `done` within 3 cycles of `core_halted` rising.
- `rst_n` low during RUNNING -> next cycle all outputs 0 and `cmd_ready = 1` once reset is released; STEP afterwards retires exactly 1 instruction.
